// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers
// and returns read data, slave error and timeout status on a valid/ready response port.
module apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // state  | meaning
  // IDLE   | no transfer; pselx=penable=0, accepts a command when the response slot is free
  // SETUP  | first APB cycle; pselx=1, penable=0
  // ACCESS | pselx=penable=1 until pready or wait-state timeout
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  assign cmd_ready = (state == IDLE) && (!rsp_valid || rsp_ready);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      paddr       <= '0;
      pselx       <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // consumption first so a same-cycle completion below wins and keeps rsp_valid high
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            paddr    <= cmd_addr;
            pwrite   <= cmd_write;
            pwdata   <= cmd_wdata;
            pselx    <= 1'b1;
            penable  <= 1'b0;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid   <= 1'b1;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= pwrite ? '0 : prdata;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            state       <= IDLE;
          end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
            rsp_valid   <= 1'b1;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            state       <= IDLE;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          pselx   <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: scoreboard of expected responses, popped on each
// response handshake, plus cycle-level phase checks in one linear stimulus sequence.
module tb_apb_requester;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } rsp_t;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout;
  logic [31:0] paddr;
  logic        pselx, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rsp_t sb[$];
  int   pop_cyc[$];

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // response monitor: every handshake pops one expected entry
  always @(negedge pclk) begin
    if (presetn === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_payload", 64'({rsp_rdata, rsp_slverr, rsp_timeout}), 64'(e));
        pop_cyc.push_back(cyc);
      end
    end
  end

  logic [31:0] a3 [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic [31:0] d3 [4] = '{32'h0, 32'h1111_2222, 32'h0, 32'h3333_4444};
  logic [31:0] r3 [4] = '{32'hA0A0_0001, 32'hBAD0_BAD0, 32'hA0A0_0003, 32'hBAD1_BAD1};
  logic        w3 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int n;
    int nacc;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_pselx", 64'(pselx), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    presetn = 1'b1;
    tick();

    // 1: zero-wait write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEAD_BEEF;
    pready = 1'b1;
    chk("t1_cmd_ready", 64'(cmd_ready), 64'd1);
    sb.push_back('{rdata: 32'h0, slverr: 1'b0, timeout: 1'b0});
    tick();
    cmd_valid = 1'b0;
    chk("t1_setup", 64'({pselx, penable}), 64'b10);
    chk("t1_paddr", 64'(paddr), 64'h10);
    chk("t1_pwrite", 64'(pwrite), 64'd1);
    chk("t1_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    tick();
    chk("t1_access", 64'({pselx, penable, rsp_valid}), 64'b110);
    tick();
    chk("t1_done", 64'({pselx, penable, rsp_valid}), 64'b001);
    tick();
    chk("t1_rsp_cleared", 64'(rsp_valid), 64'd0);

    // 2: read with two wait states
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h14; cmd_wdata = 32'h5555_5555;
    pready = 1'b0; prdata = 32'h1111_1111;
    sb.push_back('{rdata: 32'hCAFE_0001, slverr: 1'b0, timeout: 1'b0});
    tick();
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFF0;
    chk("t2_setup", 64'({pselx, penable}), 64'b10);
    tick();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (penable !== 1'b1) break;
      n++;
      chk("t2_paddr_stable", 64'(paddr), 64'h14);
      if (n == 3) begin pready = 1'b1; prdata = 32'hCAFE_0001; end
      tick();
    end
    chk("t2_penable_cycles", 64'(n), 64'd3);
    chk("t2_done", 64'({pselx, rsp_valid}), 64'b01);
    tick();

    // 3: four back-to-back commands, zero wait, mixed read/write
    pready = 1'b1; prdata = 32'h0; pop_cyc.delete();
    nacc = 0;
    cmd_valid = 1'b1; cmd_write = w3[0]; cmd_addr = a3[0]; cmd_wdata = d3[0];
    for (int k = 0; k < 12; k++) begin
      chk("t3_cmd_ready", 64'(cmd_ready), 64'(k % 3 == 0));
      if (k % 3 == 0) begin
        sb.push_back('{rdata: (w3[nacc] ? 32'h0 : r3[nacc]), slverr: 1'b0, timeout: 1'b0});
        prdata = r3[nacc];
      end
      tick();
      if (k % 3 == 0) begin
        chk("t3_paddr", 64'(paddr), 64'(a3[nacc]));
        nacc++;
        if (nacc < 4) begin
          cmd_write = w3[nacc]; cmd_addr = a3[nacc]; cmd_wdata = d3[nacc];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      chk("t3_pselx", 64'(pselx), 64'(k % 3 != 2));
      chk("t3_penable", 64'(penable), 64'(k % 3 == 1));
    end
    tick();
    chk("t3_rsp_count", 64'(pop_cyc.size()), 64'd4);
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++) chk("t3_rsp_spacing", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd3);

    // 4: slave error, response held under backpressure
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h5A5A_5A5A;
    sb.push_back('{rdata: 32'h5A5A_5A5A, slverr: 1'b1, timeout: 1'b0});
    tick();
    cmd_addr = 32'h44;
    tick();
    tick();
    pslverr = 1'b0; prdata = 32'h0;
    chk("t4_err_rsp", 64'({rsp_valid, rsp_slverr, rsp_timeout}), 64'b110);
    for (int i = 0; i < 5; i++) begin
      chk("t4_cmd_ready_blocked", 64'(cmd_ready), 64'd0);
      tick();
      chk("t4_hold", 64'({rsp_valid, rsp_slverr, rsp_timeout, pselx}), 64'b1100);
      chk("t4_hold_rdata", 64'(rsp_rdata), 64'h5A5A_5A5A);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    chk("t4_rsp_cleared", 64'(rsp_valid), 64'd0);

    // 5: timeout after exactly four ACCESS cycles
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    pready = 1'b0; prdata = 32'hFFFF_FFFF;
    sb.push_back('{rdata: 32'h0, slverr: 1'b1, timeout: 1'b1});
    tick();
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (penable !== 1'b1) break;
      n++;
    end
    chk("t5_access_cycles", 64'(n), 64'd4);
    chk("t5_abort", 64'({pselx, rsp_valid, rsp_timeout}), 64'b011);
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h1234;
    pready = 1'b1;
    sb.push_back('{rdata: 32'h0, slverr: 1'b0, timeout: 1'b0});
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("t5_next_ok", 64'({rsp_valid, rsp_timeout, rsp_slverr}), 64'b100);
    tick();

    // 6: reset during ACCESS, then a clean read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t6_in_access", 64'(penable), 64'd1);
    presetn = 1'b0;
    tick();
    chk("t6_rst_outputs", 64'({pselx, penable, rsp_valid}), 64'b000);
    chk("t6_rst_paddr", 64'(paddr), 64'd0);
    chk("t6_rst_idle", 64'(cmd_ready), 64'd1);
    presetn = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h34;
    pready = 1'b1; prdata = 32'h600D_600D;
    sb.push_back('{rdata: 32'h600D_600D, slverr: 1'b0, timeout: 1'b0});
    tick();
    cmd_valid = 1'b0;
    chk("t6_paddr", 64'(paddr), 64'h34);
    tick();
    tick();
    chk("t6_rsp", 64'(rsp_valid), 64'd1);
    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
